csr_ctrl: RTL and testbench

Sequencer and arbiter in front of the CSR register file. Accepts CSR read-modify-write requests from the core's execute stage and from the debug port, grants one at a time using round-robin, and runs a fixed read-then-write sequence on the register-file port. Handles CSRRW/CSRRS/CSRRC semantics, write suppression, and illegal-access detection. Returns the old CSR value to the granted requester.

---
 rtl/csr_ctrl_if.sv | 36 +++
 rtl/csr_ctrl.sv | 66 ++++++
 tb/tb_csr_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/csr_ctrl_if.sv
// csr_ctrl_if: request/response and register-file port bundle for csr_ctrl
//   core_*/dbg_* : request fields from the two requesters, done pulses back
//   rsp_*        : old CSR value and illegal flag for the granted requester
//   busy         : sequencer is not idle
//   csr_*        : register-file port (addr, combinational rdata, we, wdata)
interface csr_ctrl_if;
  logic        core_req;
  logic [11:0] core_addr;
  logic [1:0]  core_op;
  logic [31:0] core_wdata;
  logic        core_wsuppress;
  logic        dbg_req;
  logic [11:0] dbg_addr;
  logic [1:0]  dbg_op;
  logic [31:0] dbg_wdata;
  logic        dbg_wsuppress;
  logic        core_done;
  logic        dbg_done;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        busy;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  modport master (
    output core_req, core_addr, core_op, core_wdata, core_wsuppress,
    output dbg_req, dbg_addr, dbg_op, dbg_wdata, dbg_wsuppress, csr_rdata,
    input  core_done, dbg_done, rsp_rdata, rsp_illegal, busy, csr_addr, csr_we, csr_wdata
  );
  modport slave (
    input  core_req, core_addr, core_op, core_wdata, core_wsuppress,
    input  dbg_req, dbg_addr, dbg_op, dbg_wdata, dbg_wsuppress, csr_rdata,
    output core_done, dbg_done, rsp_rdata, rsp_illegal, busy, csr_addr, csr_we, csr_wdata
  );
endinterface

// File: rtl/csr_ctrl.sv
// csr_ctrl: round-robin CSR read-modify-write sequencer for core and debug requesters
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : csr_ctrl_if.slave carrying both request ports, responses and the register-file port
module csr_ctrl (
  input logic     clk,
  input logic     rst_n,
  csr_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t      state, state_nx;
  logic        gnt_dbg, last_dbg, pick_dbg, any_req, wsup_q;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] wdata_q, old_q, wval;
  logic        legal, ro, intend, illegal, wr;
  assign any_req = bus.core_req | bus.dbg_req;
  // on a tie, whoever was not served last wins
  assign pick_dbg = bus.dbg_req & (~bus.core_req | ~last_dbg);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (any_req ? RD : IDLE) : (state == RD) ? WR : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt_dbg  <= 1'b0;
      last_dbg <= 1'b1;
      addr_q   <= '0;
      op_q     <= '0;
      wdata_q  <= '0;
      wsup_q   <= 1'b0;
      old_q    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_dbg <= pick_dbg;
        addr_q  <= pick_dbg ? bus.dbg_addr : bus.core_addr;
        op_q    <= pick_dbg ? bus.dbg_op : bus.core_op;
        wdata_q <= pick_dbg ? bus.dbg_wdata : bus.core_wdata;
        wsup_q  <= pick_dbg ? bus.dbg_wsuppress : bus.core_wsuppress;
      end
      if (state == RD) old_q <= bus.csr_rdata;
      if (state == WR) last_dbg <= gnt_dbg;
    end
  // legality and write data depend only on latched fields and the captured old value
  always_comb begin
    legal   = addr_q inside {12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                             12'h300, 12'h305, 12'h340, 12'h341};
    ro      = addr_q[11:10] == 2'b11;
    intend  = (op_q == 2'b01) | (op_q[1] & ~wsup_q);
    illegal = ~legal | (op_q == 2'b00) | (intend & ro);
    wval    = (op_q == 2'b01) ? wdata_q : (op_q == 2'b10) ? (old_q | wdata_q) : (old_q & ~wdata_q);
  end
  always_comb begin
    wr              = state == WR;
    bus.core_done   = wr & ~gnt_dbg;
    bus.dbg_done    = wr & gnt_dbg;
    bus.rsp_rdata   = (wr & ~illegal) ? old_q : '0;
    bus.rsp_illegal = wr & illegal;
    bus.busy        = state != IDLE;
    bus.csr_addr    = addr_q;
    bus.csr_we      = wr & intend & ~illegal;
    bus.csr_wdata   = wr ? wval : '0;
  end
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: randomized self-checking bench for csr_ctrl against a behavioural model
module tb_csr_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  csr_ctrl_if bus();
  csr_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [11:0] LEGAL [0:9] = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81,
                                          12'hC82, 12'h300, 12'h305, 12'h340, 12'h341};
  int vec = 0;
  int errs = 0;
  bit tb_last = 1'b1;
  bit exp_dbg, e_ill, e_we;
  logic [31:0] e_rd, e_wd;
  logic [11:0] exp_addr;
  logic o_busy1, o_done1, o_cd, o_dd, o_ill, o_we, o_busy3, o_done3, o_we3;
  logic [11:0] o_addr1;
  logic [31:0] o_rd, o_wd;
  function automatic void model(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                                input bit ws, input logic [31:0] old, output bit ill,
                                output logic [31:0] rd, output bit we, output logic [31:0] wv);
    bit known = 0;
    bit intent;
    for (int i = 0; i < 10; i++) if (LEGAL[i] == a) known = 1;
    intent = (op == 2'd1) || (op != 2'd0 && !ws);
    ill = !known || op == 2'd0 || (intent && a >= 12'hC00);
    rd = ill ? 32'd0 : old;
    we = intent && !ill;
    wv = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
  endfunction
  task automatic idle_inputs();
    bus.core_req = 0; bus.core_addr = 0; bus.core_op = 0; bus.core_wdata = 0; bus.core_wsuppress = 0;
    bus.dbg_req = 0; bus.dbg_addr = 0; bus.dbg_op = 0; bus.dbg_wdata = 0; bus.dbg_wsuppress = 0;
    bus.csr_rdata = 0;
  endtask
  task automatic txn(input bit cr, input logic [11:0] ca, input logic [1:0] co, input logic [31:0] cw,
                     input bit cs, input bit dr, input logic [11:0] da, input logic [1:0] dop,
                     input logic [31:0] dw, input bit ds, input logic [31:0] old);
    bus.core_req = cr; bus.core_addr = ca; bus.core_op = co; bus.core_wdata = cw; bus.core_wsuppress = cs;
    bus.dbg_req = dr; bus.dbg_addr = da; bus.dbg_op = dop; bus.dbg_wdata = dw; bus.dbg_wsuppress = ds;
    bus.csr_rdata = old;
    exp_dbg = dr && (!cr || !tb_last);
    exp_addr = exp_dbg ? da : ca;
    model(exp_addr, exp_dbg ? dop : co, exp_dbg ? dw : cw, exp_dbg ? ds : cs, old, e_ill, e_rd, e_we, e_wd);
    @(negedge clk);
    o_busy1 = bus.busy; o_addr1 = bus.csr_addr; o_done1 = bus.core_done | bus.dbg_done;
    @(negedge clk);
    o_cd = bus.core_done; o_dd = bus.dbg_done; o_rd = bus.rsp_rdata; o_ill = bus.rsp_illegal;
    o_we = bus.csr_we; o_wd = bus.csr_wdata;
    bus.core_req = 0; bus.dbg_req = 0;
    @(negedge clk);
    o_busy3 = bus.busy; o_done3 = bus.core_done | bus.dbg_done; o_we3 = bus.csr_we;
    tb_last = exp_dbg;
  endtask
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    vec++; if ({bus.core_done, bus.dbg_done, bus.csr_we, bus.rsp_illegal} !== 4'b0) begin
      errs++; $display("FAIL reset_strobes got %b exp 0000", {bus.core_done, bus.dbg_done, bus.csr_we, bus.rsp_illegal}); end
    vec++; if (bus.csr_addr !== 12'h0) begin errs++; $display("FAIL reset_addr got %h exp 000", bus.csr_addr); end
    vec++; if ({bus.rsp_rdata, bus.csr_wdata} !== 64'h0) begin
      errs++; $display("FAIL reset_data got %h/%h exp 0/0", bus.rsp_rdata, bus.csr_wdata); end
    rst_n = 1;
    tb_last = 1;
    @(negedge clk);
  endtask
  task automatic test_core_rs();
    txn(1, 12'h340, 2'b10, 32'h0000_00F0, 0, 0, 0, 0, 0, 0, 32'h1234_5600);
    vec++; if (o_busy1 !== 1'b1 || o_addr1 !== 12'h340 || o_done1 !== 1'b0) begin
      errs++; $display("FAIL rs_rd_cycle got busy=%0b addr=%h done=%0b exp 1/340/0", o_busy1, o_addr1, o_done1); end
    vec++; if (o_cd !== 1'b1 || o_dd !== 1'b0) begin errs++; $display("FAIL rs_done got %0b%0b exp 10", o_cd, o_dd); end
    vec++; if (o_rd !== 32'h1234_5600) begin errs++; $display("FAIL rs_rdata got %h exp 12345600", o_rd); end
    vec++; if (o_we !== 1'b1 || o_ill !== 1'b0) begin errs++; $display("FAIL rs_we_ill got %0b%0b exp 10", o_we, o_ill); end
    vec++; if (o_wd !== 32'h1234_56F0) begin errs++; $display("FAIL rs_wdata got %h exp 123456f0", o_wd); end
    vec++; if (o_busy3 !== 1'b0 || o_done3 !== 1'b0 || o_we3 !== 1'b0) begin
      errs++; $display("FAIL rs_idle got busy=%0b done=%0b we=%0b exp 000", o_busy3, o_done3, o_we3); end
  endtask
  task automatic test_contention();
    logic [31:0] old = 32'hA5A5_0F0F;
    bit ci, di, cwe, dwe;
    logic [31:0] crd, cwd, drd, dwd;
    bit want_core, want_dbg;
    rst_n = 0; @(negedge clk); rst_n = 1; tb_last = 1;
    model(12'h341, 2'b10, 32'h0000_0011, 0, old, ci, crd, cwe, cwd);
    model(12'h305, 2'b11, 32'hFFFF_0000, 0, old, di, drd, dwe, dwd);
    bus.core_req = 1; bus.core_addr = 12'h341; bus.core_op = 2'b10; bus.core_wdata = 32'h0000_0011; bus.core_wsuppress = 0;
    bus.dbg_req = 1; bus.dbg_addr = 12'h305; bus.dbg_op = 2'b11; bus.dbg_wdata = 32'hFFFF_0000; bus.dbg_wsuppress = 0;
    bus.csr_rdata = old;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      want_core = (k % 3 == 2) && ((k / 3) % 2 == 0);
      want_dbg = (k % 3 == 2) && ((k / 3) % 2 == 1);
      vec++; if (bus.core_done !== want_core || bus.dbg_done !== want_dbg) begin
        errs++; $display("FAIL contend_cycle%0d got core=%0b dbg=%0b exp %0b%0b", k, bus.core_done, bus.dbg_done, want_core, want_dbg); end
      if (want_core) begin
        vec++; if (bus.rsp_rdata !== crd || bus.csr_wdata !== cwd || bus.csr_we !== cwe) begin
          errs++; $display("FAIL contend_core_rsp got %h/%h/%0b exp %h/%h/%0b", bus.rsp_rdata, bus.csr_wdata, bus.csr_we, crd, cwd, cwe); end
      end
      if (want_dbg) begin
        vec++; if (bus.rsp_rdata !== drd || bus.csr_wdata !== dwd || bus.csr_we !== dwe) begin
          errs++; $display("FAIL contend_dbg_rsp got %h/%h/%0b exp %h/%h/%0b", bus.rsp_rdata, bus.csr_wdata, bus.csr_we, drd, dwd, dwe); end
      end
    end
    bus.core_req = 0; bus.dbg_req = 0;
    tb_last = 1;
    @(negedge clk);
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL contend_idle got busy=%0b exp 0", bus.busy); end
  endtask
  task automatic test_readonly();
    txn(1, 12'hC00, 2'b01, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 32'h0000_1234);
    vec++; if (o_ill !== 1'b1 || o_rd !== 32'h0 || o_we !== 1'b0) begin
      errs++; $display("FAIL ro_rw got ill=%0b rd=%h we=%0b exp 1/0/0", o_ill, o_rd, o_we); end
    txn(1, 12'hC00, 2'b10, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 32'h0000_ABCD);
    vec++; if (o_ill !== 1'b0 || o_rd !== 32'h0000_ABCD || o_we !== 1'b0 || o_cd !== 1'b1) begin
      errs++; $display("FAIL ro_rs_sup got ill=%0b rd=%h we=%0b done=%0b exp 0/abcd/0/1", o_ill, o_rd, o_we, o_cd); end
  endtask
  task automatic test_bad_access();
    txn(0, 0, 0, 0, 0, 1, 12'h123, 2'b11, 32'h1, 0, 32'h5555_5555);
    vec++; if (o_ill !== 1'b1 || o_dd !== 1'b1 || o_cd !== 1'b0 || o_we !== 1'b0) begin
      errs++; $display("FAIL bad_addr got ill=%0b dd=%0b cd=%0b we=%0b exp 1/1/0/0", o_ill, o_dd, o_cd, o_we); end
    txn(1, 12'h340, 2'b00, 32'h1, 0, 0, 0, 0, 0, 0, 32'h7777_7777);
    vec++; if (o_ill !== 1'b1 || o_we !== 1'b0 || o_rd !== 32'h0) begin
      errs++; $display("FAIL bad_op got ill=%0b we=%0b rd=%h exp 1/0/0", o_ill, o_we, o_rd); end
  endtask
  task automatic test_rc();
    txn(1, 12'h300, 2'b11, 32'h0000_0008, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    vec++; if (o_wd !== 32'hFFFF_FFF7 || o_we !== 1'b1 || o_ill !== 1'b0) begin
      errs++; $display("FAIL rc got wd=%h we=%0b ill=%0b exp fffffff7/1/0", o_wd, o_we, o_ill); end
  endtask
  task automatic test_reset_mid();
    bus.dbg_req = 1; bus.dbg_addr = 12'h340; bus.dbg_op = 2'b01; bus.dbg_wdata = 32'h1111_2222; bus.dbg_wsuppress = 0;
    bus.csr_rdata = 32'h3333_4444;
    @(negedge clk);
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_rd_busy got %0b exp 1", bus.busy); end
    rst_n = 0;
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.dbg_done !== 1'b0 || bus.csr_we !== 1'b0 || bus.csr_addr !== 12'h0) begin
      errs++; $display("FAIL mid_reset got busy=%0b dd=%0b we=%0b addr=%h exp 0/0/0/000", bus.busy, bus.dbg_done, bus.csr_we, bus.csr_addr); end
    bus.dbg_req = 0;
    @(negedge clk);
    vec++; if (bus.dbg_done !== 1'b0 || bus.csr_we !== 1'b0) begin
      errs++; $display("FAIL mid_reset_hold got dd=%0b we=%0b exp 00", bus.dbg_done, bus.csr_we); end
    rst_n = 1;
    tb_last = 1;
    txn(1, 12'h341, 2'b01, 32'hCAFE_0001, 0, 1, 12'h340, 2'b01, 32'hCAFE_0002, 0, 32'h0);
    vec++; if (o_cd !== 1'b1 || o_dd !== 1'b0 || o_wd !== 32'hCAFE_0001) begin
      errs++; $display("FAIL mid_next_tie got cd=%0b dd=%0b wd=%h exp 1/0/cafe0001", o_cd, o_dd, o_wd); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      bit cr, dr;
      logic [11:0] a [2];
      int sel;
      for (int r = 0; r < 2; r++) begin
        sel = $urandom_range(0, 13);
        a[r] = (sel < 10) ? LEGAL[sel] : 12'($urandom);
      end
      sel = $urandom_range(0, 2);
      cr = sel != 1; dr = sel != 0;
      txn(cr, a[0], 2'($urandom), $urandom, 1'($urandom), dr, a[1], 2'($urandom), $urandom, 1'($urandom), $urandom);
      vec++; if (o_busy1 !== 1'b1 || o_addr1 !== exp_addr) begin
        errs++; $display("FAIL rnd%0d_rd got busy=%0b addr=%h exp 1/%h", n, o_busy1, o_addr1, exp_addr); end
      vec++; if (o_cd !== !exp_dbg || o_dd !== exp_dbg) begin
        errs++; $display("FAIL rnd%0d_grant got cd=%0b dd=%0b exp dbg=%0b", n, o_cd, o_dd, exp_dbg); end
      vec++; if (o_ill !== e_ill || o_rd !== e_rd) begin
        errs++; $display("FAIL rnd%0d_rsp got ill=%0b rd=%h exp %0b/%h", n, o_ill, o_rd, e_ill, e_rd); end
      vec++; if (o_we !== e_we) begin errs++; $display("FAIL rnd%0d_we got %0b exp %0b", n, o_we, e_we); end
      if (e_we) begin
        vec++; if (o_wd !== e_wd) begin errs++; $display("FAIL rnd%0d_wdata got %h exp %h", n, o_wd, e_wd); end
      end
      vec++; if (o_busy3 !== 1'b0 || o_done3 !== 1'b0 || o_we3 !== 1'b0) begin
        errs++; $display("FAIL rnd%0d_idle got busy=%0b done=%0b we=%0b exp 000", n, o_busy3, o_done3, o_we3); end
    end
  endtask
  initial begin
    test_reset();
    test_core_rs();
    test_contention();
    test_readonly();
    test_bad_access();
    test_rc();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", vec);
    $fatal(1);
  end
endmodule
